// File: rtl/div_unit.sv
// 32-bit restoring divider for the MIPS HI/LO path: signed DIV and unsigned DIVU.
// Fixed 34-cycle latency, 1-cycle completion on divide-by-zero, and cancel on pipeline flush.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [32:0] prem_q, prem_d;
    logic [31:0] work_q, work_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    logic        a_neg, b_neg, accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        a_neg   = is_signed & dividend[31];
        b_neg   = is_signed & divisor[31];
        a_mag   = a_neg ? (32'd0 - dividend) : dividend;
        b_mag   = b_neg ? (32'd0 - divisor) : divisor;
        shifted = {prem_q[31:0], work_q[31]};
        // Extra headroom bit so the borrow is unambiguous for any 33-bit shifted value.
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        accept  = start & ((state_q == StIdle) | (state_q == StDone));
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prem_d      = prem_q;
        work_d      = work_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StCalc: begin
                if (diff[33]) begin
                    prem_d = shifted;
                    work_d = {work_q[30:0], 1'b0};
                end else begin
                    prem_d = diff[32:0];
                    work_d = {work_q[30:0], 1'b1};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quotient_d  = neg_quo_q ? (32'd0 - work_q) : work_q;
                remainder_d = neg_rem_q ? (32'd0 - prem_q[31:0]) : prem_q[31:0];
                state_d     = StDone;
            end
            StDone: state_d = StIdle;
            default: ;
        endcase

        if (accept) begin
            if (divisor == 32'd0) begin
                state_d     = StDone;
                quotient_d  = 32'hFFFF_FFFF;
                remainder_d = dividend;
                dbz_d       = 1'b1;
            end else begin
                state_d   = StCalc;
                count_d   = 5'd0;
                prem_d    = 33'd0;
                work_d    = a_mag;
                dvs_d     = b_mag;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                dbz_d     = 1'b0;
            end
        end

        // A flush wins over everything and leaves the architectural results untouched.
        if (cancel) begin
            state_d     = StIdle;
            count_d     = 5'd0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            dbz_d       = dbz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            count_q     <= 5'd0;
            prem_q      <= 33'd0;
            work_q      <= 32'd0;
            dvs_q       <= 32'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prem_q      <= prem_d;
            work_q      <= work_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StCalc) || (state_q == StFix);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
